// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-memory port between the fetch unit (fixed priority)
// and the debug/program-loader port, with a wait counter bounding loader starvation.
module imem_port_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_SIZE   = 1024,
  parameter int                    MAX_WAIT   = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        f_req_valid_i,
  output logic                        f_req_ready_o,
  input  logic [DATA_WIDTH-1:0]       f_addr_i,
  output logic                        f_rsp_valid_o,
  input  logic                        f_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]       f_rsp_data_o,
  output logic                        f_rsp_err_o,
  input  logic                        d_req_valid_i,
  output logic                        d_req_ready_o,
  input  logic                        d_we_i,
  input  logic [DATA_WIDTH-1:0]       d_addr_i,
  input  logic [DATA_WIDTH-1:0]       d_wdata_i,
  output logic                        d_rsp_valid_o,
  input  logic                        d_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]       d_rsp_data_o,
  output logic                        d_rsp_err_o,
  output logic [$clog2(MEM_SIZE)-1:0] mem_idx_o,
  output logic                        mem_we_o,
  output logic [DATA_WIDTH-1:0]       mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i
);

  localparam int                    IDX_W     = $clog2(MEM_SIZE);
  localparam int                    CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [DATA_WIDTH-1:0] MEM_WORDS = DATA_WIDTH'(MEM_SIZE);
  localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_WAIT);

  logic [DATA_WIDTH-1:0] f_word_s, d_word_s;
  logic                  f_in_range_s, d_in_range_s;
  logic [IDX_W-1:0]      f_idx_s, d_idx_s;
  logic                  f_elig_s, d_elig_s;
  logic                  f_grant_s, d_grant_s;
  logic [DATA_WIDTH-1:0] f_rdata_s, d_rdata_s;

  logic                  f_rsp_valid_r, d_rsp_valid_r;
  logic [DATA_WIDTH-1:0] f_rsp_data_r, d_rsp_data_r;
  logic                  f_rsp_err_r, d_rsp_err_r;
  logic [CNT_W-1:0]      wait_cnt_r;

  assign f_word_s     = f_addr_i >> 2'd2;
  assign d_word_s     = d_addr_i >> 2'd2;
  assign f_in_range_s = (f_word_s < MEM_WORDS);
  assign d_in_range_s = (d_word_s < MEM_WORDS);
  assign f_idx_s      = f_addr_i[IDX_W+1:2];
  assign d_idx_s      = d_addr_i[IDX_W+1:2];

  // Eligibility and grant; the loader overrides fetch once it has waited MAX_WAIT cycles
  always_comb begin
    f_elig_s  = f_req_valid_i & (~f_rsp_valid_r | f_rsp_ready_i);
    d_elig_s  = d_req_valid_i & (~d_rsp_valid_r | d_rsp_ready_i);
    f_grant_s = 1'b0;
    d_grant_s = 1'b0;
    if (rst) begin
      f_grant_s = 1'b0;
      d_grant_s = 1'b0;
    end else if (d_elig_s && (!f_elig_s || (wait_cnt_r >= MAX_CNT))) begin
      d_grant_s = 1'b1;
    end else if (f_elig_s) begin
      f_grant_s = 1'b1;
    end else begin
      f_grant_s = 1'b0;
      d_grant_s = 1'b0;
    end
  end

  assign f_req_ready_o = f_grant_s;
  assign d_req_ready_o = d_grant_s;
  assign mem_idx_o     = d_grant_s ? d_idx_s : f_idx_s;
  assign mem_we_o      = d_grant_s & d_we_i & d_in_range_s;
  assign mem_wdata_o   = d_wdata_i;

  assign f_rdata_s = f_in_range_s ? mem_rdata_i : NOP_INSTR;
  assign d_rdata_s = d_we_i ? d_wdata_i : (d_in_range_s ? mem_rdata_i : NOP_INSTR);

  // Fetch response register: loads on grant, clears when drained, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rsp_valid_r <= 1'b0;
      f_rsp_data_r  <= '0;
      f_rsp_err_r   <= 1'b0;
    end else if (f_grant_s) begin
      f_rsp_valid_r <= 1'b1;
      f_rsp_data_r  <= f_rdata_s;
      f_rsp_err_r   <= ~f_in_range_s;
    end else if (f_rsp_ready_i) begin
      f_rsp_valid_r <= 1'b0;
    end else begin
      f_rsp_valid_r <= f_rsp_valid_r;
    end
  end

  // Debug response register: writes echo their data, reads return memory (or NOP)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rsp_valid_r <= 1'b0;
      d_rsp_data_r  <= '0;
      d_rsp_err_r   <= 1'b0;
    end else if (d_grant_s) begin
      d_rsp_valid_r <= 1'b1;
      d_rsp_data_r  <= d_rdata_s;
      d_rsp_err_r   <= ~d_in_range_s;
    end else if (d_rsp_ready_i) begin
      d_rsp_valid_r <= 1'b0;
    end else begin
      d_rsp_valid_r <= d_rsp_valid_r;
    end
  end

  // Saturating count of consecutive cycles the loader was eligible but refused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (d_grant_s) begin
      wait_cnt_r <= '0;
    end else if (d_elig_s && (wait_cnt_r < MAX_CNT)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign f_rsp_valid_o = f_rsp_valid_r;
  assign f_rsp_data_o  = f_rsp_data_r;
  assign f_rsp_err_o   = f_rsp_err_r;
  assign d_rsp_valid_o = d_rsp_valid_r;
  assign d_rsp_data_o  = d_rsp_data_r;
  assign d_rsp_err_o   = d_rsp_err_r;

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between two requesters.
  - Requester 0 is the core fetch unit (read-only).
  - Requester 1 is the debug/program-loader port (read or write).
- Fetch has fixed priority. A wait counter guarantees the loader is granted within a bounded number of cycles.
- Drives the memory's combinational word-indexed port and returns registered, per-requester responses under valid/ready flow control.

Parameters:
- DATA_WIDTH, 32, instruction/data word width.
- MEM_SIZE, 1024, memory depth in words (power of two).
- MAX_WAIT, 4, consecutive cycles requester 1 may be refused before it takes priority (≥1).
- NOP_INSTR, 32'h00000013, data returned for out-of-range reads.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- f_req_valid_i  in  1  fetch request valid
- f_req_ready_o  out  1  fetch request accepted this cycle
- f_addr_i  in  DATA_WIDTH  fetch byte address
- f_rsp_valid_o  out  1  fetch response valid
- f_rsp_ready_i  in  1  fetch response consumed
- f_rsp_data_o  out  DATA_WIDTH  fetched instruction
- f_rsp_err_o  out  1  fetch address out of range
- d_req_valid_i  in  1  debug request valid
- d_req_ready_o  out  1  debug request accepted
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  DATA_WIDTH  debug byte address
- d_wdata_i  in  DATA_WIDTH  write data
- d_rsp_valid_o  out  1  debug response valid
- d_rsp_ready_i  in  1  debug response consumed
- d_rsp_data_o  out  DATA_WIDTH  read data, or echoed write data
- d_rsp_err_o  out  1  debug address out of range
- mem_idx_o  out  $clog2(MEM_SIZE)  word index to memory
- mem_we_o  out  1  memory write strobe
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  combinational memory read data

Behaviour:
- Reset (async, active-high): all *_rsp_valid_o, *_rsp_err_o, mem_we_o = 0; *_rsp_data_o = 0; wait counter = 0.
- Address decoding:
  - Word index = addr >> 2; addr[1:0] ignored.
  - In range iff (addr >> 2) < MEM_SIZE.
  - Out of range: no memory write; read data = NOP_INSTR; err = 1 in the response.
- Slot free: requester k's slot is free iff its rsp_valid is 0, or rsp_valid & rsp_ready are both 1 this cycle.
- Eligibility: requester k is eligible iff req_valid & slot free.
- Grant, at most one per cycle:
  - If both are eligible: requester 1 wins iff wait_cnt ≥ MAX_WAIT, otherwise requester 0 wins.
  - If only one is eligible, it wins.
- req_ready_o is combinational: 1 only for the granted requester.
- Memory drive:
  - mem_idx_o = the granted requester's index; when idle it holds the fetch index.
  - mem_we_o = grant to requester 1 & d_we_i & in range. It is combinational and lasts exactly one cycle per accepted write.
  - mem_wdata_o = d_wdata_i.
- Latency: request accepted in cycle N → rsp_valid = 1 in cycle N+1.
  - Read response data is mem_rdata_i sampled in cycle N.
  - Write response data is d_wdata_i sampled in cycle N.
- Response hold: rsp_valid, data and err stay stable until rsp_ready. A new grant in the same cycle as the drain overwrites them back-to-back, giving 1 transfer/cycle per requester.
- Wait counter (saturating at MAX_WAIT):
  - Increments each cycle requester 1 is eligible but not granted.
  - Clears on a requester-1 grant.
  - Holds when requester 1 is not eligible.
- Bound: requester 1 is always granted within MAX_WAIT+1 cycles of becoming continuously eligible.
- Fetch and debug accesses to the same index in consecutive cycles: a read issued after a write observes the written value, because the memory writes on the clock edge.
- Reset mid-operation: pending responses are discarded, the counter clears, and no write strobe is generated while rst is high.

Test Plan:
- Reset then idle → all rsp_valid = 0, mem_we_o = 0. Fetch reads addr 0x0 with memory[0] = 0x00100093 → f_rsp_valid the next cycle, data 0x00100093, err = 0.
- Fetch streams addr 0,4,8 with f_rsp_ready held high → three responses on consecutive cycles, f_req_ready_o = 1 every cycle.
- Debug write 0xDEADBEEF to addr 0x10, then fetch addr 0x10 → mem_we_o pulses once with mem_idx_o = 4. The fetch response is 0xDEADBEEF and the debug response echoes 0xDEADBEEF.
- Fetch is valid every cycle and debug reads continuously, MAX_WAIT = 4 → debug is granted on its 5th eligible cycle. The counter resets and the fetch stream resumes the next cycle.
- Fetch addr 0x1000 (MEM_SIZE = 1024) → data 0x00000013, err = 1. A debug write to 0x1000 → mem_we_o stays 0 and d_rsp_err_o = 1.
- Fetch response stalled (f_rsp_ready = 0 for 3 cycles) → f_req_ready_o = 0 and the response is held stable. Debug is granted meanwhile. Asserting rst mid-stall clears all valids asynchronously.
